// File: rtl/map_write_arbiter.sv
`timescale 1ns/1ps
// map_write_arbiter: per-producer FIFOs drained into the map_mem write port, one write per cycle.
// Latency: an entry pushed at clk edge k is written (wr_en registered) at edge k+1 at the earliest.
// Backpressure: in_ready = FIFO not full; a request presented while not ready is dropped and flagged.

module map_write_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Circular pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Entry storage carries no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; the caller never pushes when full nor pops when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

module map_write_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int FIXED_PRIO = 0,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic                            clear_overflow,
  output logic [NUM_PORTS-1:0]            overflow,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [PORT_W-1:0]               wr_port
);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] pop;
  logic [ENTRY_W-1:0]   head [NUM_PORTS];
  logic [PORT_W-1:0]    rr_ptr;
  logic                 grant;
  logic [PORT_W-1:0]    win;

  // Readiness depends on FIFO occupancy only; a pop in the same cycle does not free a full FIFO.
  assign in_ready = ~full;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign pop[p] = grant && (win == PORT_W'(p));

    map_write_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid[p] && !full[p]),
      .push_data ({in_addr[p*ADDR_WIDTH +: ADDR_WIDTH], in_data[p*DATA_WIDTH +: DATA_WIDTH]}),
      .pop       (pop[p]),
      .head      (head[p]),
      .full      (full[p]),
      .empty     (empty[p])
    );
  end

  // i-th candidate in search order: plain index for fixed priority, rotated past rr_ptr otherwise.
  function automatic int cand(input int i, input logic [PORT_W-1:0] ptr);
    return (FIXED_PRIO != 0) ? i : (int'(ptr) + 1 + i) % NUM_PORTS;
  endfunction

  // Pick the first non-empty port in search order.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant && !empty[cand(i, rr_ptr)]) begin
        grant = 1'b1;
        win   = PORT_W'(cand(i, rr_ptr));
      end
    end
  end

  // Register the granted head as the map_mem write; address/data/port hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_port <= '0;
      rr_ptr  <= PORT_W'(NUM_PORTS - 1);
    end else begin
      wr_en <= grant;
      if (grant) begin
        wr_addr <= head[win][ENTRY_W-1:DATA_WIDTH];
        wr_data <= head[win][DATA_WIDTH-1:0];
        wr_port <= win;
        rr_ptr  <= win;
      end
    end
  end

  // Sticky drop flags; a new drop in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= '0;
    else        overflow <= (overflow & ~{NUM_PORTS{clear_overflow}}) | (in_valid & full);
  end
endmodule

// File: tb/tb_map_write_arbiter.sv
`timescale 1ns/1ps
// Bench for map_write_arbiter: a round-robin and a fixed-priority instance share address/data
// buses and reset; expected writes are queued per instance and checked by negedge monitors.
module tb_map_write_arbiter;
  typedef struct packed {
    logic [1:0] port;
    logic [7:0] addr;
    logic [1:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid, fp_valid;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        clear_overflow;

  logic [3:0]  in_ready, overflow, fp_in_ready, fp_overflow;
  logic        wr_en, fp_wr_en;
  logic [7:0]  wr_addr, fp_wr_addr;
  logic [1:0]  wr_data, fp_wr_data, wr_port, fp_wr_port;

  wr_t exp_q[$];
  wr_t fp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  seen;

  // Writes predicted for the directed scenarios, derived by hand.
  int         t4_p   [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  int         t4_k   [14] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, 8};
  logic [3:0] t4_rdy [8]  = '{4'hf, 4'hf, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
  logic [3:0] t5_rdy [6]  = '{4'hf, 4'hf, 4'h7, 4'h7, 4'h7, 4'h7};

  always #5 clk = ~clk;

  map_write_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(in_ready), .clear_overflow(clear_overflow), .overflow(overflow),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_port(wr_port)
  );

  map_write_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(fp_valid), .in_addr(in_addr), .in_data(in_data),
    .in_ready(fp_in_ready), .clear_overflow(clear_overflow), .overflow(fp_overflow),
    .wr_en(fp_wr_en), .wr_addr(fp_wr_addr), .wr_data(fp_wr_data), .wr_port(fp_wr_port)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entry issued by port p in stimulus step k.
  function automatic wr_t mk(input int p, input int k);
    wr_t e;
    e.port = 2'(p);
    e.addr = 8'(p * 16 + k);
    e.data = 2'((p + k) % 4);
    return e;
  endfunction

  task automatic set_bus(input int k);
    for (int p = 0; p < 4; p++) begin
      in_addr[p*8 +: 8] = 8'(p * 16 + k);
      in_data[p*2 +: 2] = 2'((p + k) % 4);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = '0;
    fp_valid = '0;
    clear_overflow = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_check(input string name, input int cycles);
    seen = 0;
    repeat (cycles) begin
      tick();
      if (wr_en || fp_wr_en) seen++;
    end
    chk(name, seen, 0);
  endtask

  // Round-robin monitor: every write must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rr_unexpected: got write port=%0d addr=%0d data=%0d, required none", wr_port, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("rr_write", {20'b0, wr_port, wr_addr, wr_data}, {20'b0, e});
      end
    end
  end

  // Fixed-priority monitor.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && fp_wr_en) begin
      if (fp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fp_unexpected: got write port=%0d addr=%0d data=%0d, required none", fp_wr_port, fp_wr_addr, fp_wr_data);
      end else begin
        e = fp_q.pop_front();
        chk("fp_write", {20'b0, fp_wr_port, fp_wr_addr, fp_wr_data}, {20'b0, e});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    fp_valid = '0;
    in_addr = '0;
    in_data = '0;
    clear_overflow = 1'b0;

    // 1. Reset state and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 4'hf);
    chk("rst_wr_addr_port", {wr_addr, wr_data, wr_port}, 0);
    chk("rst_fp_in_ready", fp_in_ready, 4'hf);
    rst_n = 1'b1;
    idle_check("idle_after_reset", 10);

    // 2. Single pulse on port 2
    in_addr[16 +: 8] = 8'd5;
    in_data[4 +: 2]  = 2'd2;
    in_valid = 4'b0100;
    exp_q.push_back('{port: 2'd2, addr: 8'd5, data: 2'd2});
    tick();
    in_valid = '0;
    tick();
    chk("single_wr_en_high", wr_en, 1);
    tick();
    chk("single_wr_en_low", wr_en, 0);

    // 3. All ports pulse together right after reset
    do_reset();
    set_bus(1);
    for (int p = 0; p < 4; p++) exp_q.push_back(mk(p, 1));
    in_valid = 4'hf;
    tick();
    in_valid = '0;
    repeat (5) tick();
    chk("burst_wr_en_low", wr_en, 0);
    chk("burst_drained", exp_q.size(), 0);

    // 4. All ports valid every cycle for 8 cycles
    do_reset();
    for (int i = 0; i < 14; i++) exp_q.push_back(mk(t4_p[i], t4_k[i]));
    for (int k = 1; k <= 8; k++) begin
      set_bus(k);
      in_valid = 4'hf;
      chk($sformatf("rr_in_ready_k%0d", k), in_ready, t4_rdy[k-1]);
      tick();
    end
    in_valid = '0;
    chk("rr_overflow_set", overflow, 4'hf);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("rr_overflow_cleared", overflow, 0);
    repeat (8) tick();
    chk("rr_drained", exp_q.size(), 0);
    chk("rr_wr_en_low", wr_en, 0);

    // 5. Fixed priority: ports 0 and 3 valid; clear collides with a new drop in the last cycle
    do_reset();
    for (int k = 1; k <= 6; k++) fp_q.push_back(mk(0, k));
    fp_q.push_back(mk(3, 1));
    fp_q.push_back(mk(3, 2));
    for (int k = 1; k <= 6; k++) begin
      set_bus(k);
      fp_valid = 4'b1001;
      clear_overflow = (k == 6);
      chk($sformatf("fp_in_ready_k%0d", k), fp_in_ready, t5_rdy[k-1]);
      tick();
    end
    fp_valid = '0;
    clear_overflow = 1'b0;
    chk("fp_overflow_set_wins", fp_overflow, 4'b1000);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("fp_overflow_cleared", fp_overflow, 0);
    repeat (4) tick();
    chk("fp_drained", fp_q.size(), 0);
    chk("fp_wr_en_low", fp_wr_en, 0);

    // 6. Asynchronous reset while three FIFOs hold entries
    do_reset();
    exp_q.push_back(mk(0, 1));
    for (int k = 1; k <= 2; k++) begin
      set_bus(k);
      in_valid = 4'b0111;
      tick();
    end
    in_valid = '0;
    chk("pre_reset_wr_en", wr_en, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_wr_en", wr_en, 0);
    chk("async_reset_in_ready", in_ready, 4'hf);
    tick();
    tick();
    rst_n = 1'b1;
    idle_check("idle_after_async_reset", 10);
    chk("async_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
